// File: rtl/p405s_itlb_shadow_cmp.sv
// Shadow instruction-TLB compare: a small fully associative EPN array with a
// masked-compare lookup (1-cycle latency) and a two-state fill engine.
module p405s_itlb_shadow_cmp #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned EPN_W   = 22,
    parameter int unsigned SIZE_W  = 7
) (
    input  logic                        CB,
    input  logic                        Reset_NEG,
    input  logic                        lookupValid,
    input  logic [0:EPN_W-1]            isEA,
    input  logic                        msrIrL2,
    input  logic                        writeShadow,
    input  logic                        isAbort_NEG,
    input  logic                        fillReq,
    input  logic [0:EPN_W-1]            fillEPN,
    input  logic [0:SIZE_W-1]           fillSize,
    input  logic                        invalidateAll,
    output logic                        lookupReady,
    output logic                        fillAck,
    output logic                        Hit,
    output logic                        Miss,
    output logic                        multiHit,
    output logic [$clog2(ENTRIES)-1:0]  hitIndex,
    output logic                        resultValid,
    output logic                        stateDhitSel
);

    localparam int unsigned IDX_W     = $clog2(ENTRIES);
    localparam int unsigned MASK_BASE = EPN_W - 2 * SIZE_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } fill_state_e;

    fill_state_e         state_q;
    fill_state_e         state_d;

    logic [ENTRIES-1:0]  ent_valid;
    logic [0:EPN_W-1]    ent_epn  [ENTRIES];
    logic [0:SIZE_W-1]   ent_size [ENTRIES];

    logic [IDX_W-1:0]    victim_ptr;
    logic [IDX_W-1:0]    victim_q;
    logic                victim_rep_q;
    logic [0:EPN_W-1]    fill_epn_q;
    logic [0:SIZE_W-1]   fill_size_q;

    logic                load_fill;
    logic                do_write;

    logic                any_match;
    logic                multi_match;
    logic [IDX_W-1:0]    match_idx;
    logic                inv_found;
    logic [IDX_W-1:0]    inv_idx;
    logic                accept;

    // Size bit k removes one EPN bit pair from the compare, low-order pairs last.
    function automatic logic [0:EPN_W-1] care_mask(input logic [0:SIZE_W-1] sz);
        logic [0:EPN_W-1] m;
        m = '1;
        for (int k = 0; k < int'(SIZE_W); k++) begin
            if (sz[k]) begin
                m[MASK_BASE + 2 * k]     = 1'b0;
                m[MASK_BASE + 2 * k + 1] = 1'b0;
            end
        end
        return m;
    endfunction

    assign stateDhitSel = ~(writeShadow & isAbort_NEG);
    assign lookupReady  = stateDhitSel;
    assign accept       = lookupValid & lookupReady;

    // Lookup compare against the pre-edge array contents.
    always_comb begin
        any_match   = 1'b0;
        multi_match = 1'b0;
        match_idx   = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (ent_valid[i] && (((ent_epn[i] ^ isEA) & care_mask(ent_size[i])) == '0)) begin
                if (any_match) begin
                    multi_match = 1'b1;
                end else begin
                    match_idx = IDX_W'(i);
                end
                any_match = 1'b1;
            end
        end
    end

    // Victim choice: lowest invalid entry, otherwise the round-robin pointer.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!ent_valid[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CB or negedge Reset_NEG) begin
        if (!Reset_NEG) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fillReq && !invalidateAll) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_fill = 1'b0;
        do_write  = 1'b0;
        case (state_q)
            S_IDLE:  load_fill = fillReq & ~invalidateAll;
            S_WRITE: do_write  = ~invalidateAll;
            default: ;
        endcase
    end

    // Valid bits, fill latch, replacement pointer and fill handshake.
    always_ff @(posedge CB or negedge Reset_NEG) begin
        if (!Reset_NEG) begin
            ent_valid    <= '0;
            victim_ptr   <= '0;
            victim_q     <= '0;
            victim_rep_q <= 1'b0;
            fill_epn_q   <= '0;
            fill_size_q  <= '0;
            fillAck      <= 1'b0;
        end else begin
            fillAck <= do_write;
            if (invalidateAll) begin
                ent_valid <= '0;
            end else if (do_write) begin
                ent_valid[victim_q] <= 1'b1;
            end
            if (do_write && victim_rep_q) begin
                victim_ptr <= (victim_ptr == IDX_W'(ENTRIES - 1)) ? '0 : victim_ptr + IDX_W'(1);
            end
            if (load_fill) begin
                victim_q     <= inv_found ? inv_idx : victim_ptr;
                victim_rep_q <= ~inv_found;
                fill_epn_q   <= fillEPN;
                fill_size_q  <= fillSize;
            end
        end
    end

    // Entry payload carries no reset; its valid bit qualifies it.
    always_ff @(posedge CB) begin
        if (do_write) begin
            ent_epn[victim_q]  <= fill_epn_q;
            ent_size[victim_q] <= fill_size_q;
        end
    end

    always_ff @(posedge CB or negedge Reset_NEG) begin
        if (!Reset_NEG) begin
            resultValid <= 1'b0;
            Hit         <= 1'b0;
            Miss        <= 1'b0;
            multiHit    <= 1'b0;
            hitIndex    <= '0;
        end else begin
            resultValid <= accept;
            if (accept) begin
                Hit      <= msrIrL2 & any_match;
                Miss     <= ~(msrIrL2 & any_match);
                multiHit <= multi_match;
                hitIndex <= match_idx;
            end
        end
    end

endmodule

// File: tb/tb_p405s_itlb_shadow_cmp.sv
// Directed bench for p405s_itlb_shadow_cmp with a lookup-result scoreboard.
module tb_p405s_itlb_shadow_cmp;

    typedef struct packed {
        logic       hit;
        logic       miss;
        logic [1:0] idx;
        logic       multi;
    } exp_t;

    logic        CB;
    logic        Reset_NEG;
    logic        lookupValid;
    logic [0:21] isEA;
    logic        msrIrL2;
    logic        writeShadow;
    logic        isAbort_NEG;
    logic        fillReq;
    logic [0:21] fillEPN;
    logic [0:6]  fillSize;
    logic        invalidateAll;
    logic        lookupReady;
    logic        fillAck;
    logic        Hit;
    logic        Miss;
    logic        multiHit;
    logic [1:0]  hitIndex;
    logic        resultValid;
    logic        stateDhitSel;

    int   checks;
    int   failures;
    exp_t sb[$];

    p405s_itlb_shadow_cmp #(.ENTRIES(4), .EPN_W(22), .SIZE_W(7)) dut (
        .CB            (CB),
        .Reset_NEG     (Reset_NEG),
        .lookupValid   (lookupValid),
        .isEA          (isEA),
        .msrIrL2       (msrIrL2),
        .writeShadow   (writeShadow),
        .isAbort_NEG   (isAbort_NEG),
        .fillReq       (fillReq),
        .fillEPN       (fillEPN),
        .fillSize      (fillSize),
        .invalidateAll (invalidateAll),
        .lookupReady   (lookupReady),
        .fillAck       (fillAck),
        .Hit           (Hit),
        .Miss          (Miss),
        .multiHit      (multiHit),
        .hitIndex      (hitIndex),
        .resultValid   (resultValid),
        .stateDhitSel  (stateDhitSel)
    );

    initial CB = 1'b0;
    always #5 CB = ~CB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [21:0] ea, input logic ir, input logic eh,
                          input logic [1:0] ei, input logic em, input string tag);
        exp_t e;
        lookupValid = 1'b1;
        isEA        = ea;
        msrIrL2     = ir;
        sb.push_back('{hit: eh, miss: ~eh, idx: ei, multi: em});
        @(posedge CB);
        #1;
        lookupValid = 1'b0;
        chk({tag, ".rv"}, 32'(resultValid), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".hit"},   32'(Hit),      32'(e.hit));
            chk({tag, ".miss"},  32'(Miss),     32'(e.miss));
            chk({tag, ".idx"},   32'(hitIndex), 32'(e.idx));
            chk({tag, ".multi"}, 32'(multiHit), 32'(e.multi));
        end
    endtask

    task automatic fill(input logic [21:0] epn, input logic [6:0] sz, input string tag);
        fillReq  = 1'b1;
        fillEPN  = epn;
        fillSize = sz;
        @(posedge CB);
        #1;
        fillReq = 1'b0;
        chk({tag, ".ack_lo"}, 32'(fillAck), 32'd0);
        @(posedge CB);
        #1;
        chk({tag, ".ack_hi"}, 32'(fillAck), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks        = 0;
        failures      = 0;
        Reset_NEG     = 1'b0;
        lookupValid   = 1'b0;
        isEA          = '0;
        msrIrL2       = 1'b0;
        writeShadow   = 1'b0;
        isAbort_NEG   = 1'b1;
        fillReq       = 1'b0;
        fillEPN       = '0;
        fillSize      = '0;
        invalidateAll = 1'b0;

        repeat (2) @(posedge CB);
        #1;
        chk("rst.rv",    32'(resultValid), 32'd0);
        chk("rst.hit",   32'(Hit),         32'd0);
        chk("rst.miss",  32'(Miss),        32'd0);
        chk("rst.multi", 32'(multiHit),    32'd0);
        chk("rst.idx",   32'(hitIndex),    32'd0);
        chk("rst.ack",   32'(fillAck),     32'd0);
        chk("rst.dhit",  32'(stateDhitSel), 32'd1);
        Reset_NEG = 1'b1;

        // Basic fill and hit into the lowest invalid entry.
        fill(22'h12345, 7'b0000000, "f_a");
        lookup(22'h12345, 1'b1, 1'b1, 2'd0, 1'b0, "lk_a");

        // Masked compare ignores the two low EPN bits.
        fill(22'h00100, 7'b0000001, "f_b");
        lookup(22'h00103, 1'b1, 1'b1, 2'd1, 1'b0, "lk_b_mask");
        lookup(22'h00104, 1'b1, 1'b0, 2'd0, 1'b0, "lk_b_out");

        @(posedge CB);
        #1;
        chk("hold.rv",   32'(resultValid), 32'd0);
        chk("hold.miss", 32'(Miss),        32'd1);
        chk("hold.hit",  32'(Hit),         32'd0);

        // Duplicate EPN in entries 2 and 3.
        fill(22'h2AAAA, 7'b0000000, "f_d2");
        fill(22'h2AAAA, 7'b0000000, "f_d3");
        lookup(22'h2AAAA, 1'b1, 1'b1, 2'd2, 1'b1, "lk_dup");
        lookup(22'h2AAAA, 1'b0, 1'b0, 2'd2, 1'b1, "lk_dup_ir0");

        // Round-robin replacement once all entries are valid.
        fill(22'h3F001, 7'b0000000, "f_5");
        lookup(22'h3F001, 1'b1, 1'b1, 2'd0, 1'b0, "lk_5");
        lookup(22'h12345, 1'b1, 1'b0, 2'd0, 1'b0, "lk_a_gone");
        fill(22'h3F002, 7'b0000000, "f_6");
        lookup(22'h3F002, 1'b1, 1'b1, 2'd1, 1'b0, "lk_6");
        lookup(22'h00100, 1'b1, 1'b0, 2'd0, 1'b0, "lk_b_gone");

        // Un-aborted shadow write stalls lookups.
        writeShadow = 1'b1;
        isAbort_NEG = 1'b1;
        lookupValid = 1'b1;
        isEA        = 22'h3F002;
        msrIrL2     = 1'b1;
        #1;
        chk("stall.dhit",  32'(stateDhitSel), 32'd0);
        chk("stall.ready", 32'(lookupReady),  32'd0);
        @(posedge CB);
        #1;
        chk("stall.rv", 32'(resultValid), 32'd0);
        isAbort_NEG = 1'b0;
        #1;
        chk("abort.ready", 32'(lookupReady), 32'd1);
        lookup(22'h3F002, 1'b1, 1'b1, 2'd1, 1'b0, "lk_abort");
        writeShadow = 1'b0;
        isAbort_NEG = 1'b1;

        // invalidateAll on the WRITE edge drops the fill and flushes.
        fillReq = 1'b1;
        fillEPN = 22'h11111;
        fillSize = '0;
        @(posedge CB);
        #1;
        fillReq       = 1'b0;
        invalidateAll = 1'b1;
        @(posedge CB);
        #1;
        invalidateAll = 1'b0;
        chk("inv.ack_edge", 32'(fillAck), 32'd0);
        @(posedge CB);
        #1;
        chk("inv.ack_after", 32'(fillAck), 32'd0);
        lookup(22'h11111, 1'b1, 1'b0, 2'd0, 1'b0, "lk_inv_g");
        lookup(22'h3F001, 1'b1, 1'b0, 2'd0, 1'b0, "lk_inv_5");
        lookup(22'h2AAAA, 1'b1, 1'b0, 2'd0, 1'b0, "lk_inv_dup");

        // fillReq held through WRITE yields a single fill.
        fillReq  = 1'b1;
        fillEPN  = 22'h01234;
        fillSize = '0;
        @(posedge CB);
        #1;
        chk("held.ack_lo", 32'(fillAck), 32'd0);
        @(posedge CB);
        #1;
        fillReq = 1'b0;
        chk("held.ack_hi", 32'(fillAck), 32'd1);
        @(posedge CB);
        #1;
        chk("held.ack_once", 32'(fillAck), 32'd0);
        fill(22'h06789, 7'b0000000, "f_y");
        lookup(22'h01234, 1'b1, 1'b1, 2'd0, 1'b0, "lk_x");
        lookup(22'h06789, 1'b1, 1'b1, 2'd1, 1'b0, "lk_y");

        // Reset in WRITE aborts the fill.
        fillReq = 1'b1;
        fillEPN = 22'h07777;
        @(posedge CB);
        #1;
        fillReq   = 1'b0;
        Reset_NEG = 1'b0;
        #1;
        chk("rstw.ack", 32'(fillAck),     32'd0);
        chk("rstw.rv",  32'(resultValid), 32'd0);
        chk("rstw.hit", 32'(Hit),         32'd0);
        chk("rstw.idx", 32'(hitIndex),    32'd0);
        @(posedge CB);
        #1;
        Reset_NEG = 1'b1;
        chk("rstw.ack2", 32'(fillAck), 32'd0);
        lookup(22'h07777, 1'b1, 1'b0, 2'd0, 1'b0, "lk_rst_z");
        lookup(22'h01234, 1'b1, 1'b0, 2'd0, 1'b0, "lk_rst_x");

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p405s_itlb_shadow_cmp.md
P405S_ITLB_SHADOW_CMP -- requirements
Module: p405s_itlb_shadow_cmp

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, meaning the number of shadow ITLB entries (2..16).
REQ-002 SHALL have parameter EPN_W, default 22, meaning the EPN and effective-address width in bits (even).
REQ-003 SHALL have parameter SIZE_W, default 7, meaning the number of size-mask bits (SIZE_W <= EPN_W/2).
REQ-004 SHALL have one clock, CB, and an asynchronous active-low reset, Reset_NEG.
REQ-005 Ports, in order (name, direction, width, meaning):
- CB  in  1  clock, rising edge.
- Reset_NEG  in  1  asynchronous active-low reset.
- lookupValid  in  1  lookup request this cycle.
- isEA  in  [0:EPN_W-1]  instruction-side EA page bits.
- msrIrL2  in  1  instruction relocation enable.
- writeShadow  in  1  shadow write in progress.
- isAbort_NEG  in  1  active-low fetch abort.
- fillReq  in  1  fill request.
- fillEPN  in  [0:EPN_W-1]  fill page number.
- fillSize  in  [0:SIZE_W-1]  fill size mask.
- invalidateAll  in  1  flush all entries.
- lookupReady  out  1  lookup accepted this cycle.
- fillAck  out  1  fill-complete pulse.
- Hit  out  1  registered hit.
- Miss  out  1  registered miss.
- multiHit  out  1  more than one entry matched.
- hitIndex  out  [$clog2(ENTRIES)-1:0]  index of the matching entry.
- resultValid  out  1  Hit, Miss and hitIndex are valid.
- stateDhitSel  out  1  equals ~(writeShadow & isAbort_NEG), combinational.

Function
REQ-006 Each entry SHALL hold valid, EPN[0:EPN_W-1] and size[0:SIZE_W-1].
REQ-007 Size bit k set SHALL exclude EPN bit pair {EPN_W-2*SIZE_W+2k, EPN_W-2*SIZE_W+2k+1} from the compare.
- All other bits compare exactly.
REQ-008 lookupReady SHALL equal stateDhitSel.
- Lookups are stalled while a shadow write proceeds un-aborted.
REQ-009 Lookup accepted on edge N (lookupValid & lookupReady):
- Match = valid & masked EPN equal, evaluated against entry state before edge N.
- resultValid, Hit, Miss, hitIndex and multiHit are registered at edge N, giving 1-cycle latency.
REQ-010 On an accepted lookup:
- Hit = msrIrL2 & any match; Miss = ~Hit.
- hitIndex = lowest matching index, else 0.
- multiHit = 1 when two or more entries match.
REQ-011 While no lookup is accepted, resultValid SHALL be 0 and Hit, Miss, hitIndex and multiHit SHALL hold their previous values.
REQ-012 Fill state machine states: IDLE and WRITE.
- IDLE -> WRITE on fillReq & ~invalidateAll; the victim is latched.
- WRITE writes the entry at the next edge, asserts fillAck for 1 cycle, then returns to IDLE.
REQ-013 Victim selection: the lowest-index invalid entry, else the round-robin pointer victimPtr.
- victimPtr advances by 1 mod ENTRIES only when a valid entry is replaced.
REQ-014 A lookup in the same cycle as the WRITE edge SHALL compare against pre-write contents.
REQ-015 invalidateAll SHALL clear every valid bit at the next edge and has priority over fill.
- In WRITE, the fill is dropped: no write, no fillAck, return to IDLE.
- The requester re-issues the fill.
REQ-016 fillReq held high while in WRITE SHALL be ignored; a new fill is accepted only from IDLE.
REQ-017 The module SHALL write the same EPN twice into different entries when asked, with no duplicate check.
- The resulting dual match is reported through multiHit.

Reset
REQ-018 While Reset_NEG = 0, asynchronously:
- all valid = 0, victimPtr = 0, fill state = IDLE;
- fillAck = 0, resultValid = 0, Hit = 0, Miss = 0, multiHit = 0, hitIndex = 0.
REQ-019 Reset asserted during WRITE SHALL abort the fill with no entry written and no fillAck.
REQ-020 Entry EPN and size fields need not be reset.
REQ-021 Reset release SHALL be synchronised externally, and the first lookup is accepted the cycle after release.

Verification (ENTRIES=4, EPN_W=22, SIZE_W=7)
REQ-022 Fill EPN 0x12345, size 0, then a lookup with isEA 0x12345 and msrIrL2=1 -> next cycle: resultValid=1, Hit=1, hitIndex=0.
REQ-023 Entry 1 with size 7'b0000001 and EPN 0x00100, lookup isEA 0x00103 -> Hit=1, hitIndex=1; lookup isEA 0x00104 -> Miss=1.
REQ-024 Five fills with all entries valid -> the fifth fill replaces entry 0 and victimPtr becomes 1; the sixth fill replaces entry 1.
REQ-025 writeShadow=1 with isAbort_NEG=1 -> stateDhitSel=0, lookupReady=0, resultValid stays 0; isAbort_NEG=0 -> lookup accepted.
REQ-026 invalidateAll in the same cycle as a WRITE edge -> no fillAck, all valid bits cleared; the next lookup gives Miss=1.
REQ-027 Duplicate EPN in entries 2 and 3 -> Hit=1, hitIndex=2, multiHit=1; the same lookup with msrIrL2=0 -> Miss=1.
